// File: rtl/l_shift_pkg.sv
// Shared types for the shift-and-add multiplicand register: FSM states,
// command encodings and the step-counter width helper.
package l_shift_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOADED,
    SHIFT,
    DONE
  } state_t;

  localparam logic [1:0] CMD_HOLD  = 2'd0;
  localparam logic [1:0] CMD_LOAD  = 2'd1;
  localparam logic [1:0] CMD_SHIFT = 2'd2;

  function automatic int unsigned count_w(input int unsigned data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/shift_step_counter.sv
// Saturating step counter with clear, enable and a registered pulse on the
// step that reaches MAX.
module shift_step_counter
  import l_shift_pkg::*;
#(
  parameter int unsigned MAX   = 4,
  parameter int unsigned CNT_W = count_w(MAX)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX - 1);
  localparam logic [CNT_W-1:0] TOP  = CNT_W'(MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      done  <= 1'b0;
    end else if (clear) begin
      count <= '0;
      done  <= 1'b0;
    end else if (enable && (count != TOP)) begin
      count <= count + CNT_W'(1);
      done  <= (count == LAST);
    end else begin
      done  <= 1'b0;
    end
  end

endmodule

// File: rtl/l_shift_a.sv
// Left-shift multiplicand register with step counting and status flags.
// Define L_SHIFT_ROTATE_EN to rotate the top bit into bit 0 instead of a_sin.
module l_shift_a
  import l_shift_pkg::*;
#(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned REG_W  = 8
) (
  input  logic                       Clk,
  input  logic                       reset,
  input  logic                       a_enable,
  input  logic                       a_L,
  input  logic [DATA_W-1:0]          a_data,
  input  logic                       a_sin,
  output logic [REG_W-1:0]           A_result,
  output logic                       a_msb,
  output logic                       a_zero,
  output logic                       a_ovf,
  output logic [count_w(DATA_W)-1:0] a_count,
  output logic                       a_busy,
  output logic                       a_done
);

  localparam int unsigned CNT_W = count_w(DATA_W);

  state_t             state;
  state_t             next_state;
  logic [1:0]         cmd;
  logic               shift_ok;
  logic               last_shift;
  logic               in_bit;
  logic [REG_W-1:0]   shifted;
  logic [REG_W-1:0]   loaded;

  // a_L wins over a_enable, so both high is a shift
  always_comb begin
    cmd = CMD_HOLD;
    if (a_L)
      cmd = CMD_SHIFT;
    else if (a_enable)
      cmd = CMD_LOAD;
  end

  always_comb begin
    shift_ok   = (cmd == CMD_SHIFT) && ((state == LOADED) || (state == SHIFT));
    last_shift = shift_ok && (a_count == CNT_W'(DATA_W - 1));
  end

`ifdef L_SHIFT_ROTATE_EN
  always_comb in_bit = A_result[REG_W-1];
`else
  always_comb in_bit = a_sin;
`endif

  always_comb begin
    shifted = {A_result[REG_W-2:0], in_bit};
    loaded  = REG_W'(a_data);
  end

  always_comb begin
    next_state = state;
    if (cmd == CMD_LOAD)
      next_state = LOADED;
    else if (shift_ok)
      next_state = last_shift ? DONE : SHIFT;
  end

  always_ff @(posedge Clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      A_result <= '0;
      a_msb    <= 1'b0;
      a_zero   <= 1'b1;
      a_ovf    <= 1'b0;
    end else if (cmd == CMD_LOAD) begin
      A_result <= loaded;
      a_msb    <= 1'b0;
      a_zero   <= (loaded == '0);
      a_ovf    <= 1'b0;
    end else if (shift_ok) begin
      A_result <= shifted;
      a_msb    <= A_result[REG_W-1];
      a_zero   <= (shifted == '0);
      a_ovf    <= a_ovf | A_result[REG_W-1];
    end
  end

  always_comb a_busy = (state == LOADED) || (state == SHIFT);

  shift_step_counter #(
    .MAX   (DATA_W),
    .CNT_W (CNT_W)
  ) u_counter (
    .clk    (Clk),
    .reset  (reset),
    .clear  (cmd == CMD_LOAD),
    .enable (shift_ok),
    .count  (a_count),
    .done   (a_done)
  );

endmodule
